fetch_unit: RTL and testbench
=============================

# fetch_unit

Front-end fetch stage directly downstream of the BTB. Holds the architectural fetch PC, drives it to the BTB for lookup, and issues one-at-a-time instruction reads to the instruction memory port. Instruction words are buffered with their PC and BTB prediction in an instruction queue read by decode. The ROB can redirect fetch at any time.

## Interface
Parameters:
- RESET_PC, 32'h1eceb000, PC loaded on reset.
- IQ_DEPTH, 8, instruction-queue entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  Reset: synchronous, active-high. Clock is clk.
- btb_pc  out  32  PC presented to the BTB this cycle; always equals the fetch PC register.
- btb_next_pc  in  32  BTB predicted next PC (combinational from btb_pc).
- btb_taken  in  1  BTB predicts taken.
- imem_addr  out  32  instruction read address.
- imem_rmask  out  4  4'hf in the request cycle, else 4'h0.
- imem_rdata  in  32  instruction word, valid with imem_resp.
- imem_resp  in  1  one-cycle read response.
- redirect_valid  in  1  ROB flush/mispredict redirect.
- redirect_pc  in  32  new fetch PC.
- iq_deq  in  1  decode pops the head entry.
- iq_empty  out  1  queue empty.
- iq_pc, iq_inst, iq_pred_target  out  32 each  head entry fields.
- iq_pred_taken  out  1  head entry prediction.

## Operation
- FSM states: IDLE (no read outstanding), WAIT (read outstanding, result wanted), DISCARD (read outstanding, result stale).
- Request issue, combinational: issue = state==IDLE && !redirect_valid && (count < IQ_DEPTH). On issue: imem_rmask=4'hf, imem_addr=pc. Inflight registers capture {pc, btb_taken, btb_next_pc}; pc <= btb_next_pc; state -> WAIT.
- When no request is issued, imem_addr = pc and imem_rmask = 0.
- WAIT + imem_resp: push {inflight pc, imem_rdata, inflight taken, inflight target}; state -> IDLE.
- DISCARD + imem_resp: no push; state -> IDLE.
- Redirect has the highest priority:
  - pc <= redirect_pc and the queue is cleared (count, head and tail set to 0).
  - WAIT -> DISCARD; DISCARD stays DISCARD; IDLE stays IDLE.
  - Redirect coincident with imem_resp: the response is dropped and the state -> IDLE.
  - Redirect coincident with iq_deq: the deq is ignored.
- Queue:
  - Circular buffer with wrapping head and tail pointers and a count of width $clog2(IQ_DEPTH)+1.
  - Push and pop in the same cycle are both performed, and count is unchanged.
  - iq_deq while empty is ignored.
  - A push cannot occur when full, because issue requires a free slot and only one read is ever outstanding.
- Head outputs are driven from the head entry and forced to 0 when empty.
- All PC arithmetic is 32-bit modulo; pc+4 wraps at 2^32.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, count=0, iq_empty=1, iq_* fields=0, imem_rmask=0, imem_addr=RESET_PC, btb_pc=RESET_PC.
- The first request is issued in the first cycle with rst low.
- Latency: a response in cycle N makes the entry visible (iq_empty=0) in cycle N+1. The next issue is no earlier than N+1.
- Peak throughput: one instruction per 2 cycles with 1-cycle memory.
- Redirect in cycle N: a request to redirect_pc is issued no earlier than N+1, and in N+1 only if state is IDLE.
- rst mid-operation: an outstanding response arriving after reset is ignored, because the state is IDLE after reset. Memory must not respond to pre-reset requests after reset is released.

## Configuration
- FETCH_BTB_EN defined: prediction uses btb_next_pc and btb_taken as described above.
- FETCH_BTB_EN undefined:
  - btb_next_pc and btb_taken are ignored.
  - Next pc = pc+4.
  - The stored pred_taken = 0 and pred_target = pc+4.
  - btb_pc is still driven.

## Structure
- rv32i_types package holds:
  - fetch_pkt_t struct {pc, inst, pred_taken, pred_target}.
  - fetch_state_t enum {IDLE, WAIT, DISCARD}.
- RESET_PC stays a module parameter.
- One sub-module: fetch_queue, a parameterized synchronous FIFO of fetch_pkt_t with push, pop, clear, full, empty and count.

## Test plan
- Reset, memory responds 1 cycle after each request, no deq: requests go to 1eceb000, …04, …08, … and issue stops after IQ_DEPTH=8 entries. Entries have pred_taken=0.
- BTB model returns taken to 1eceb100 for pc 1eceb008: the entry for …008 has pred_taken=1 and pred_target=1eceb100, and the next request address is 1eceb100.
- Redirect to 1eceb200 while a read is outstanding: iq_empty=1 next cycle, the stale response is not pushed, and the next request is to 1eceb200.
- Redirect in the same cycle as imem_resp and iq_deq: the response is dropped, the queue is empty, and the state is IDLE.
- Queue full, then iq_deq asserted for one cycle: exactly one new request is issued, and the head-pointer wraparound preserves order.
- FETCH_BTB_EN undefined with a BTB model driving taken: all requests remain sequential (pc+4) and all pred_taken=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: the instruction-queue packet and fetch FSM state.
// No logic here; imported by fetch_unit and fetch_queue.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch packets with synchronous clear; head visible the cycle after push.
// Backpressure: push ignored when full, pop ignored when empty, clear wins over both.
module fetch_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_pkt_t push_dat,
  input  logic       pop,
  input  logic       clear,
  output fetch_pkt_t head_dat,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  fetch_pkt_t    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !full && !clear;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[tail] <= push_dat;
  end

  assign head_dat = empty ? '0 : mem[head];

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC, BTB lookup and one-outstanding imem reads into an instruction queue (BTB use under FETCH_BTB_EN).
// Response in cycle N visible at the queue head in N+1; issue stalls while the queue is full or a read is outstanding.
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          IQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] btb_pc,
  input  logic [31:0] btb_next_pc,
  input  logic        btb_taken,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        iq_deq,
  output logic        iq_empty,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pred_target,
  output logic        iq_pred_taken
);

  localparam int CW = $clog2(IQ_DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic [31:0]   infl_pc;
  logic [31:0]   infl_tgt;
  logic          infl_taken;
  logic [31:0]   pred_next;
  logic          pred_taken;
  logic          issue;
  logic          push;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  fetch_pkt_t    push_pkt;
  fetch_pkt_t    head_pkt;
  logic          unused_ok;

`ifdef FETCH_BTB_EN
  assign pred_next  = btb_next_pc;
  assign pred_taken = btb_taken;
`else
  assign pred_next  = pc + 32'd4;
  assign pred_taken = 1'b0;
`endif

  assign unused_ok = ^{q_full, btb_next_pc, btb_taken};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    issue     = (state == IDLE) && !rst && !redirect_valid && (q_count < CW'(IQ_DEPTH));
    if (redirect_valid) begin
      pc_nxt = redirect_pc;
      // A response landing with the redirect retires the stale read immediately.
      unique case (state)
        IDLE:    state_nxt = IDLE;
        WAIT:    state_nxt = imem_resp ? IDLE : DISCARD;
        DISCARD: state_nxt = imem_resp ? IDLE : DISCARD;
        default: state_nxt = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            state_nxt = WAIT;
            pc_nxt    = pred_next;
          end
        end
        WAIT: begin
          if (imem_resp) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end
        end
        DISCARD: begin
          if (imem_resp) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_pc    <= '0;
      infl_taken <= 1'b0;
      infl_tgt   <= '0;
    end else if (issue) begin
      infl_pc    <= pc;
      infl_taken <= pred_taken;
      infl_tgt   <= pred_next;
    end
  end

  assign btb_pc     = pc;
  assign imem_addr  = pc;
  assign imem_rmask = issue ? 4'hf : 4'h0;

  assign push_pkt = '{pc: infl_pc, inst: imem_rdata, pred_taken: infl_taken, pred_target: infl_tgt};

  fetch_queue #(
    .DEPTH(IQ_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_pkt),
    .pop      (iq_deq),
    .clear    (redirect_valid),
    .head_dat (head_pkt),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign iq_empty       = q_empty;
  assign iq_pc          = head_pkt.pc;
  assign iq_inst        = head_pkt.inst;
  assign iq_pred_taken  = head_pkt.pred_taken;
  assign iq_pred_target = head_pkt.pred_target;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: fill/deq vector table, redirect and wrap sequences, then random traffic against a queue model.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h1eceb000;
`ifdef FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] btb_pc;
  logic [31:0] btb_next_pc;
  logic        btb_taken;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        iq_deq;
  logic        iq_empty;
  logic [31:0] iq_pc;
  logic [31:0] iq_inst;
  logic [31:0] iq_pred_target;
  logic        iq_pred_taken;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .IQ_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .btb_pc(btb_pc), .btb_next_pc(btb_next_pc), .btb_taken(btb_taken),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .iq_deq(iq_deq), .iq_empty(iq_empty),
    .iq_pc(iq_pc), .iq_inst(iq_inst), .iq_pred_target(iq_pred_target), .iq_pred_taken(iq_pred_taken)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic rmode = 1'b0;
  int mem_lat = 1;
  logic mem_pend = 1'b0;
  logic [31:0] mem_a;
  int mem_cnt = 0;
  logic issue_seen;
  logic [31:0] issue_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0bad_f00d;
  endfunction

  function automatic logic btb_tk_f(input logic [31:0] p, input logic rm);
    return (p == 32'h1eceb008) || (rm && p[5:2] == 4'hb);
  endfunction

  function automatic logic [31:0] btb_tgt_f(input logic [31:0] p, input logic rm);
    if (!btb_tk_f(p, rm)) return p + 32'd4;
    return (p == 32'h1eceb008) ? 32'h1eceb100 : p + 32'h40;
  endfunction

  assign btb_taken   = btb_tk_f(btb_pc, rmode);
  assign btb_next_pc = btb_tgt_f(btb_pc, rmode);

  function automatic logic [31:0] exp_next(input logic [31:0] p);
`ifdef FETCH_BTB_EN
    return btb_tgt_f(p, rmode);
`else
    return p + 32'd4;
`endif
  endfunction

  function automatic logic exp_tk(input logic [31:0] p);
`ifdef FETCH_BTB_EN
    return btb_tk_f(p, rmode);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic begin_cycle(input logic rv, input logic [31:0] rpc, input logic dq);
    redirect_valid = rv;
    redirect_pc    = rpc;
    iq_deq         = dq;
    imem_resp      = 1'b0;
    imem_rdata     = '0;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        imem_resp  = 1'b1;
        imem_rdata = inst_of(mem_a);
        mem_pend   = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    #1;
  endtask

  task automatic end_cycle();
    issue_seen = (imem_rmask == 4'hf);
    issue_addr = imem_addr;
    @(posedge clk);
    #1;
    if (issue_seen) begin
      mem_pend = 1'b1;
      mem_a    = issue_addr;
      mem_cnt  = mem_lat;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; iq_deq = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0; mem_pend = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rmask", {28'd0, imem_rmask}, 32'h0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_btb_pc", btb_pc, RPC);
    chk("rst_empty", {31'd0, iq_empty}, 32'd1);
    chk("rst_iq_pc", iq_pc, 32'h0);
    chk("rst_iq_inst", iq_inst, 32'h0);
    chk("rst_iq_tk", {31'd0, iq_pred_taken}, 32'h0);
    chk("rst_iq_tgt", iq_pred_target, 32'h0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        dq;
    logic [3:0]  rmask;
    logic [11:0] a_seq;
    logic [11:0] a_btb;
    logic        empty;
  } vec_t;
  vec_t tbl[23];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        tk;
    logic [31:0] tg;
  } ent_t;
  ent_t mq[$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc, m_pc, m_ipc, m_itg, rpc;
    logic m_out, m_stale, m_itk, m_issue, rv, dq;
    int popped;

    tbl[0]  = '{1'b0, 4'hf, 12'h000, 12'h000, 1'b1};
    tbl[1]  = '{1'b0, 4'h0, 12'h004, 12'h004, 1'b1};
    tbl[2]  = '{1'b0, 4'hf, 12'h004, 12'h004, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 12'h008, 12'h008, 1'b0};
    tbl[4]  = '{1'b0, 4'hf, 12'h008, 12'h008, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 12'h00c, 12'h100, 1'b0};
    tbl[6]  = '{1'b0, 4'hf, 12'h00c, 12'h100, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 12'h010, 12'h104, 1'b0};
    tbl[8]  = '{1'b0, 4'hf, 12'h010, 12'h104, 1'b0};
    tbl[9]  = '{1'b0, 4'h0, 12'h014, 12'h108, 1'b0};
    tbl[10] = '{1'b0, 4'hf, 12'h014, 12'h108, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 12'h018, 12'h10c, 1'b0};
    tbl[12] = '{1'b0, 4'hf, 12'h018, 12'h10c, 1'b0};
    tbl[13] = '{1'b0, 4'h0, 12'h01c, 12'h110, 1'b0};
    tbl[14] = '{1'b0, 4'hf, 12'h01c, 12'h110, 1'b0};
    tbl[15] = '{1'b0, 4'h0, 12'h020, 12'h114, 1'b0};
    tbl[16] = '{1'b0, 4'h0, 12'h020, 12'h114, 1'b0};
    tbl[17] = '{1'b0, 4'h0, 12'h020, 12'h114, 1'b0};
    tbl[18] = '{1'b1, 4'h0, 12'h020, 12'h114, 1'b0};
    tbl[19] = '{1'b0, 4'hf, 12'h020, 12'h114, 1'b0};
    tbl[20] = '{1'b0, 4'h0, 12'h024, 12'h118, 1'b0};
    tbl[21] = '{1'b0, 4'h0, 12'h024, 12'h118, 1'b0};
    tbl[22] = '{1'b0, 4'h0, 12'h024, 12'h118, 1'b0};

    // Fill to full with 1-cycle memory, then one deq admits exactly one new read.
    rmode = 1'b0; mem_lat = 1;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      begin_cycle(1'b0, 32'h0, tbl[i].dq);
      chk($sformatf("fill%0d_rmask", i), {28'd0, imem_rmask}, {28'd0, tbl[i].rmask});
      chk($sformatf("fill%0d_addr", i), imem_addr, {RPC[31:12], BTB_ON ? tbl[i].a_btb : tbl[i].a_seq});
      chk($sformatf("fill%0d_empty", i), {31'd0, iq_empty}, {31'd0, tbl[i].empty});
      end_cycle();
    end

    // Drain across the head-pointer wrap; order and predictions must follow the fetch stream.
    exp_pc = RPC + 32'd4;
    popped = 0;
    for (int cyc = 0; cyc < 80 && popped < 12; cyc++) begin
      dq = !iq_empty;
      begin_cycle(1'b0, 32'h0, dq);
      if (dq) begin
        chk($sformatf("drain%0d_pc", popped), iq_pc, exp_pc);
        chk($sformatf("drain%0d_inst", popped), iq_inst, inst_of(exp_pc));
        chk($sformatf("drain%0d_tk", popped), {31'd0, iq_pred_taken}, {31'd0, exp_tk(exp_pc)});
        chk($sformatf("drain%0d_tgt", popped), iq_pred_target, exp_next(exp_pc));
        exp_pc = exp_next(exp_pc);
        popped++;
      end
      end_cycle();
    end
    if (popped < 12) chk("drain_timeout", popped, 12);

    // Redirect with a read outstanding: queue clears, stale data dropped, refetch at target.
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 4; i++) begin begin_cycle(1'b0, 32'h0, 1'b0); end_cycle(); end
    mem_lat = 2;
    begin_cycle(1'b0, 32'h0, 1'b0);
    chk("rd_issue_rmask", {28'd0, imem_rmask}, 32'hf);
    chk("rd_issue_addr", imem_addr, RPC + 32'h8);
    end_cycle();
    begin_cycle(1'b1, 32'h1eceb200, 1'b0);
    chk("rd_pre_empty", {31'd0, iq_empty}, 32'd0);
    chk("rd_pre_rmask", {28'd0, imem_rmask}, 32'h0);
    end_cycle();
    begin_cycle(1'b0, 32'h0, 1'b0);
    chk("rd_post_empty", {31'd0, iq_empty}, 32'd1);
    chk("rd_discard_rmask", {28'd0, imem_rmask}, 32'h0);
    end_cycle();
    mem_lat = 1;
    begin_cycle(1'b0, 32'h0, 1'b0);
    chk("rd_stale_empty", {31'd0, iq_empty}, 32'd1);
    chk("rd_new_rmask", {28'd0, imem_rmask}, 32'hf);
    chk("rd_new_addr", imem_addr, 32'h1eceb200);
    end_cycle();
    begin_cycle(1'b0, 32'h0, 1'b0); end_cycle();
    begin_cycle(1'b0, 32'h0, 1'b0);
    chk("rd_head_pc", iq_pc, 32'h1eceb200);
    chk("rd_next_addr", imem_addr, 32'h1eceb204);
    end_cycle();

    // Redirect, response and deq all in one cycle.
    begin_cycle(1'b1, 32'h1eceb300, 1'b1);
    chk("rrd_resp_seen", {31'd0, imem_resp}, 32'd1);
    end_cycle();
    begin_cycle(1'b0, 32'h0, 1'b0);
    chk("rrd_empty", {31'd0, iq_empty}, 32'd1);
    chk("rrd_idle_rmask", {28'd0, imem_rmask}, 32'hf);
    chk("rrd_idle_addr", imem_addr, 32'h1eceb300);
    end_cycle();
    begin_cycle(1'b0, 32'h0, 1'b0); end_cycle();
    begin_cycle(1'b0, 32'h0, 1'b0);
    chk("rrd_head_pc", iq_pc, 32'h1eceb300);
    end_cycle();

    // PC arithmetic wraps at 2^32.
    begin_cycle(1'b1, 32'hfffffffc, 1'b0); end_cycle();
    begin_cycle(1'b0, 32'h0, 1'b0);
    chk("wrap_issue_addr", imem_addr, 32'hfffffffc);
    chk("wrap_issue_rmask", {28'd0, imem_rmask}, 32'hf);
    end_cycle();
    begin_cycle(1'b0, 32'h0, 1'b0);
    chk("wrap_btb_pc", btb_pc, 32'h0);
    end_cycle();
    begin_cycle(1'b0, 32'h0, 1'b0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_next_rmask", {28'd0, imem_rmask}, 32'hf);
    end_cycle();

    // Random traffic against a queue-level model of the fetch stream.
    do_reset();
    rmode = 1'b1;
    m_pc = RPC; m_out = 1'b0; m_stale = 1'b0; m_ipc = '0; m_itk = 1'b0; m_itg = '0;
    mq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rv = ($urandom_range(0, 15) == 0);
      rpc = RPC + ($urandom_range(0, 255) << 2);
      dq = 1'($urandom_range(0, 1));
      mem_lat = $urandom_range(1, 3);
      begin_cycle(rv, rpc, dq);
      m_issue = !m_out && !rv && (mq.size() < 8);
      chk("rnd_rmask", {28'd0, imem_rmask}, m_issue ? 32'hf : 32'h0);
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_btb_pc", btb_pc, m_pc);
      chk("rnd_empty", {31'd0, iq_empty}, {31'd0, mq.size() == 0});
      chk("rnd_iq_pc", iq_pc, mq.size() > 0 ? mq[0].pc : 32'h0);
      chk("rnd_iq_inst", iq_inst, mq.size() > 0 ? mq[0].inst : 32'h0);
      chk("rnd_iq_tk", {31'd0, iq_pred_taken}, {31'd0, mq.size() > 0 ? mq[0].tk : 1'b0});
      chk("rnd_iq_tgt", iq_pred_target, mq.size() > 0 ? mq[0].tg : 32'h0);
      if (rv) begin
        mq.delete();
        if (imem_resp) begin m_out = 1'b0; m_stale = 1'b0; end
        else if (m_out) m_stale = 1'b1;
        m_pc = rpc;
      end else begin
        if (dq && mq.size() > 0) void'(mq.pop_front());
        if (imem_resp && m_out && !m_stale) mq.push_back('{m_ipc, imem_rdata, m_itk, m_itg});
        if (imem_resp) begin m_out = 1'b0; m_stale = 1'b0; end
        if (m_issue) begin
          m_out = 1'b1; m_stale = 1'b0;
          m_ipc = m_pc; m_itk = exp_tk(m_pc); m_itg = exp_next(m_pc);
          m_pc = exp_next(m_pc);
        end
      end
      end_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
